sigfmd_seq: RTL and testbench
=============================

// Module: sigfmd_seq
// PURPOSE
//  Sequencer for the shared significand multiply/divide datapath. Multiply: issues one fa*fb
//  product. Divide: table lookup, Newton-Raphson reciprocal refinement, quotient and remainder
//  products, all on the one shared multiplier. Sits between the FPU issue stage and the datapath:
//  drives operand selects and register loads, handshakes with the variable-latency multiplier.
// PARAMETERS
//  NR_ITERS_DB  3  Newton-Raphson iterations, double precision (db=1)
//  NR_ITERS_SP  2  Newton-Raphson iterations, single precision (db=0)
//  ITW          2  iteration counter width; must hold max(NR_ITERS_DB, NR_ITERS_SP)
// PORTS
//  clk      in   1    clock, all state changes on the rising edge
//  rst      in   1    asynchronous, active-high reset
//  start    in   1    begin operation; sampled only in IDLE
//  fdiv     in   1    1=divide, 0=multiply; captured with start
//  db       in   1    1=double, 0=single; captured with start
//  flush    in   1    synchronous abort; overrides start and mul_rdy
//  mul_rdy  in   1    multiplier result valid this cycle
//  busy     out  1    high in every state except IDLE
//  done     out  1    1-cycle pulse, result registers final
//  op_div   out  1    captured fdiv
//  op_db    out  1    captured db
//  mul_go   out  1    1-cycle issue strobe to the multiplier
//  mul_op   out  3    0 FA*FB, 1 FB*X, 2 X*(2-A), 3 FA*X, 4 FB*Q
//  tbl_en   out  1    load the reciprocal seed X from the lookup table
//  ld_a     out  1    load A <- product
//  ld_x     out  1    load X <- product
//  ld_q     out  1    load Q <- product
//  ld_e     out  1    load E <- fa - product (remainder for rounding)
//  iter     out  ITW  current NR iteration index
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mul_go, tbl_en, ld_* = 0; mul_op, iter, op_div, op_db = 0.
//  States: IDLE, TBL, NR_A, NR_X, QUOT, REM, DONE.
//  IDLE: start=1 -> latch fdiv/db, iter=0; fdiv ? TBL : QUOT.
//  TBL: tbl_en=1 for exactly one cycle -> NR_A.
//  Multiply states (NR_A op1, NR_X op2, QUOT op3 if div else op0, REM op4):
//   - mul_go=1 only in the entry cycle; mul_op held for the whole stay in the state.
//   - mul_rdy in the entry cycle is ignored; first mul_rdy after entry -> assert the state's
//     load (NR_A ld_a, NR_X ld_x, QUOT ld_q, REM ld_e) that cycle, move on at the next edge.
//  NR_A -> NR_X. NR_X: iter==N-1 (N by op_db) -> QUOT, else iter+1 -> NR_A.
//  QUOT: op_div ? REM : DONE. REM -> DONE. DONE: done=1, busy=1, -> IDLE.
//  Latency, mul_rdy L>=1 cycles after mul_go: each multiply L+1 cycles; start at edge 0 ->
//   multiply: done in cycle L+2; divide: done in cycle 2+(2N+2)(L+1).
//  start while busy: ignored, no queueing. mul_rdy in IDLE/TBL/DONE: ignored.
//  flush=1 in any state: -> IDLE next edge, no done, no ld_* that cycle; iter cleared.
//  rst mid-operation: immediate return to reset values; any in-flight product is dropped.
//  At most one ld_* high per cycle; tbl_en and ld_* never coincide.
//  iter never exceeds N-1; counter does not wrap.
// TESTING
//  Multiply, L=2: start fdiv=0 at edge 0 -> mul_go cycle 1 op0, ld_q cycle 3, done cycle 4.
//  Double divide, L=2: start fdiv=1 db=1 -> tbl_en cycle 1, 8 mul_go, order 1,2,1,2,1,2,3,4, done cycle 26.
//  Single divide, L=1: start fdiv=1 db=0 -> 6 multiplies, iter 0..1, done cycle 14.
//  flush at cycle 7 of double divide -> IDLE cycle 8, no done; fresh start then completes normally.
//  start pulses while busy and mul_rdy in the entry cycle -> ignored, timing per clean run.
//  rst asserted mid-NR_X -> outputs at reset values immediately; next start runs from TBL.

Source files
------------

// File: rtl/sigfmd_seq.sv
// Sequencer for the shared significand multiply/divide datapath.
// Multiply issues a single FA*FB product. Divide runs a table seed, a
// Newton-Raphson reciprocal refinement, then the quotient and remainder
// products. Every product goes through the one variable-latency multiplier.
module sigfmd_seq #(
    parameter int NR_ITERS_DB = 3,
    parameter int NR_ITERS_SP = 2,
    parameter int ITW         = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           fdiv,
    input  logic           db,
    input  logic           flush,
    input  logic           mul_rdy,
    output logic           busy,
    output logic           done,
    output logic           op_div,
    output logic           op_db,
    output logic           mul_go,
    output logic [2:0]     mul_op,
    output logic           tbl_en,
    output logic           ld_a,
    output logic           ld_x,
    output logic           ld_q,
    output logic           ld_e,
    output logic [ITW-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TBL  = 3'd1,
        S_NR_A = 3'd2,
        S_NR_X = 3'd3,
        S_QUOT = 3'd4,
        S_REM  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [2:0] OP_FA_FB = 3'd0;
    localparam logic [2:0] OP_FB_X  = 3'd1;
    localparam logic [2:0] OP_X_2MA = 3'd2;
    localparam logic [2:0] OP_FA_X  = 3'd3;
    localparam logic [2:0] OP_FB_Q  = 3'd4;

    localparam logic [ITW-1:0] LAST_DB = ITW'(NR_ITERS_DB - 1);
    localparam logic [ITW-1:0] LAST_SP = ITW'(NR_ITERS_SP - 1);

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_op_div;
    logic           r_op_db;
    logic           r_mul_go;
    logic [2:0]     r_mul_op;
    logic           r_tbl_en;
    logic [ITW-1:0] r_iter;

    logic           w_take;
    logic           w_last;
    logic           w_ld_a;
    logic           w_ld_x;
    logic           w_ld_q;
    logic           w_ld_e;

    // A product is accepted on the first mul_rdy after the issue cycle
    // (r_mul_go marks the issue cycle); an abort suppresses it.
    assign w_take = mul_rdy & ~r_mul_go & ~flush;
    assign w_last = (r_iter == (r_op_db ? LAST_DB : LAST_SP));

    // Register loads follow the multiplier handshake in the same cycle.
    always_comb begin
        w_ld_a = 1'b0;
        w_ld_x = 1'b0;
        w_ld_q = 1'b0;
        w_ld_e = 1'b0;
        case (r_state)
            S_NR_A:  w_ld_a = w_take;
            S_NR_X:  w_ld_x = w_take;
            S_QUOT:  w_ld_q = w_take;
            S_REM:   w_ld_e = w_take;
            default: w_ld_a = 1'b0;
        endcase
    end

    // Sequencer state, iteration counter and registered control strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_op_div <= 1'b0;
            r_op_db  <= 1'b0;
            r_mul_go <= 1'b0;
            r_mul_op <= OP_FA_FB;
            r_tbl_en <= 1'b0;
            r_iter   <= '0;
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mul_go <= 1'b0;
            r_mul_op <= OP_FA_FB;
            r_tbl_en <= 1'b0;
            r_iter   <= '0;
        end else begin
            r_mul_go <= 1'b0;
            r_tbl_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_div <= fdiv;
                        r_op_db  <= db;
                        r_iter   <= '0;
                        r_busy   <= 1'b1;
                        if (fdiv) begin
                            r_state  <= S_TBL;
                            r_tbl_en <= 1'b1;
                        end else begin
                            r_state  <= S_QUOT;
                            r_mul_go <= 1'b1;
                            r_mul_op <= OP_FA_FB;
                        end
                    end
                end
                S_TBL: begin
                    r_state  <= S_NR_A;
                    r_mul_go <= 1'b1;
                    r_mul_op <= OP_FB_X;
                end
                S_NR_A: begin
                    if (w_take) begin
                        r_state  <= S_NR_X;
                        r_mul_go <= 1'b1;
                        r_mul_op <= OP_X_2MA;
                    end
                end
                S_NR_X: begin
                    if (w_take) begin
                        r_mul_go <= 1'b1;
                        if (w_last) begin
                            r_state  <= S_QUOT;
                            r_mul_op <= OP_FA_X;
                        end else begin
                            r_state  <= S_NR_A;
                            r_mul_op <= OP_FB_X;
                            r_iter   <= r_iter + ITW'(1);
                        end
                    end
                end
                S_QUOT: begin
                    if (w_take) begin
                        if (r_op_div) begin
                            r_state  <= S_REM;
                            r_mul_go <= 1'b1;
                            r_mul_op <= OP_FB_Q;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_REM: begin
                    if (w_take) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_mul_op <= OP_FA_FB;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_mul_op <= OP_FA_FB;
                    r_iter   <= '0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign op_div = r_op_div;
    assign op_db  = r_op_db;
    assign mul_go = r_mul_go;
    assign mul_op = r_mul_op;
    assign tbl_en = r_tbl_en;
    assign iter   = r_iter;
    assign ld_a   = w_ld_a;
    assign ld_x   = w_ld_x;
    assign ld_q   = w_ld_q;
    assign ld_e   = w_ld_e;

endmodule

// File: tb/tb_sigfmd_seq.sv
// Bench for sigfmd_seq: the bench plays the multiplier and checks every
// cycle against an operation schedule built from the product order.
module tb_sigfmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       fdiv = 1'b0;
    logic       db = 1'b0;
    logic       flush = 1'b0;
    logic       mul_rdy = 1'b0;
    logic       busy, done, op_div, op_db, mul_go, tbl_en;
    logic       ld_a, ld_x, ld_q, ld_e;
    logic [2:0] mul_op;
    logic [1:0] iter;
    logic [7:0] w_ctl;

    int n_cmp = 0;
    int n_bad = 0;

    sigfmd_seq #(.NR_ITERS_DB(3), .NR_ITERS_SP(2), .ITW(2)) dut (
        .clk(clk), .rst(rst), .start(start), .fdiv(fdiv), .db(db),
        .flush(flush), .mul_rdy(mul_rdy), .busy(busy), .done(done),
        .op_div(op_div), .op_db(op_db), .mul_go(mul_go), .mul_op(mul_op),
        .tbl_en(tbl_en), .ld_a(ld_a), .ld_x(ld_x), .ld_q(ld_q), .ld_e(ld_e),
        .iter(iter)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    assign w_ctl = {busy, done, mul_go, tbl_en, ld_a, ld_x, ld_q, ld_e};

    // Bound on total run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, then settle.
    task automatic cyc(input logic s, input logic f, input logic d, input logic fl, input logic r);
        @(posedge clk);
        #1;
        start = s; fdiv = f; db = d; flush = fl; mul_rdy = r;
        #1;
    endtask

    // One complete operation. fix_l=0 draws a random latency per product;
    // noise drives stray start pulses and early/late mul_rdy.
    task automatic run_op(input bit f, input bit d, input int fix_l, input bit noise, input int exp_done);
        int        n, t, l;
        int        ops[$];
        int        its[$];
        bit [3:0]  lds[$];
        n = d ? 3 : 2;
        if (f) begin
            for (int i = 0; i < n; i++) begin
                ops.push_back(1); lds.push_back(4'b1000); its.push_back(i);
                ops.push_back(2); lds.push_back(4'b0100); its.push_back(i);
            end
            ops.push_back(3); lds.push_back(4'b0010); its.push_back(n - 1);
            ops.push_back(4); lds.push_back(4'b0001); its.push_back(n - 1);
        end else begin
            ops.push_back(0); lds.push_back(4'b0010); its.push_back(0);
        end
        t = 0;
        cyc(1'b1, f, d, 1'b0, 1'b0);
        chk("idle_before_start", w_ctl, 8'h00);
        if (f) begin
            t++;
            cyc(noise & 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, noise & 1'($urandom));
            chk("tbl", w_ctl, 8'b1001_0000);
        end
        for (int k = 0; k < ops.size(); k++) begin
            l = (fix_l != 0) ? fix_l : int'($urandom_range(1, 4));
            t++;
            cyc(noise & 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, noise & 1'($urandom));
            chk("issue", w_ctl, 8'b1010_0000);
            chk("mul_op", 32'(mul_op), 32'(ops[k]));
            chk("iter", 32'(iter), 32'(its[k]));
            for (int j = 1; j < l; j++) begin
                t++;
                cyc(noise & 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
                chk("wait", w_ctl, 8'b1000_0000);
                chk("mul_op_hold", 32'(mul_op), 32'(ops[k]));
            end
            t++;
            cyc(noise & 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            chk("load", w_ctl, {4'b1000, lds[k]});
        end
        t++;
        cyc(noise & 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, noise & 1'($urandom));
        chk("done", w_ctl, 8'b1100_0000);
        chk("op_div", 32'(op_div), 32'(f));
        chk("op_db", 32'(op_db), 32'(d));
        if (exp_done != 0) chk("done_cycle", 32'(t), 32'(exp_done));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_after_done", w_ctl, 8'h00);
    endtask

    initial begin
        // Reset values.
        @(posedge clk);
        #1;
        chk("rst_ctl", w_ctl, 8'h00);
        chk("rst_mul_op", 32'(mul_op), 32'd0);
        chk("rst_iter", 32'(iter), 32'd0);
        chk("rst_op", {30'd0, op_div, op_db}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Directed runs with fixed latencies.
        run_op(1'b0, 1'b0, 2, 1'b0, 4);
        run_op(1'b1, 1'b1, 2, 1'b0, 26);
        run_op(1'b1, 1'b0, 1, 1'b0, 14);

        // Flush in cycle 7 of a double divide, coinciding with a product.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_tbl", w_ctl, 8'b1001_0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_pre_lda", w_ctl, 8'b1000_1000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_nrx", 32'(mul_op), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_no_load", w_ctl, 8'b1000_0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_idle", w_ctl, 8'h00);
        chk("flush_iter", 32'(iter), 32'd0);
        run_op(1'b1, 1'b1, 2, 1'b0, 26);

        // Stray start and early mul_rdy must not disturb timing.
        run_op(1'b0, 1'b0, 2, 1'b1, 4);
        run_op(1'b1, 1'b1, 2, 1'b1, 26);
        run_op(1'b1, 1'b0, 1, 1'b1, 14);

        // Asynchronous reset in the entry cycle of NR_X.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_nrx", {w_ctl, 5'd0, mul_op}, {8'b1010_0000, 8'd2});
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", w_ctl, 8'h00);
        chk("rst_mid_mul_op", 32'(mul_op), 32'd0);
        chk("rst_mid_op", {30'd0, op_div, op_db}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        run_op(1'b1, 1'b0, 1, 1'b0, 14);

        // Randomized operations with random multiplier latency.
        for (int r = 0; r < 24; r++) begin
            run_op(1'($urandom), 1'($urandom), 0, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
